// File: rtl/sqrt_disp_pkg.sv
// sqrt_disp_pkg: shared FSM states, seven-segment patterns and width helpers
package sqrt_disp_pkg;

    typedef enum logic [1:0] {IDLE, SQRT, CONV, DONE} state_t;

    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // active-low {g,f,e,d,c,b,a}; codes 10..15 never occur and stay dark
    localparam logic [15:0][6:0] SEG_TAB = {
        {6{SEG_BLANK}},
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic int cw(input int n);
        return n < 2 ? 1 : $clog2(n);
    endfunction

    function automatic longint pow10(input int d);
        longint p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: one shift-add-3 binary to BCD conversion, one bit per cycle
module bin2bcd_seq import sqrt_disp_pkg::*; #(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = cw(WIDTH);

    logic [WIDTH-1:0]    sh, src_bin;
    logic [4*DIGITS-1:0] src, adj;
    logic [CW-1:0]       cnt;

    assign busy = cnt != '0;

    // load performs the first step itself so a pass takes exactly WIDTH edges
    always_comb begin
        src     = load ? '0 : bcd;
        src_bin = load ? bin : sh;
        adj     = src;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = src[4*i +: 4] >= 4'd5 ? src[4*i +: 4] + 4'd3 : src[4*i +: 4];
    end

    // shift register, digit accumulator and step counter; done marks bcd final
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh   <= '0;
            bcd  <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= !load && cnt == CW'(1);
            if (load || busy) begin
                sh  <= src_bin << 1;
                bcd <= (4*DIGITS)'({adj, src_bin[WIDTH-1]});
                cnt <= load ? CW'(WIDTH - 1) : cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sqrt_bcd_display.sv
// sqrt_bcd_display: integer square root with multiplexed seven-segment readout
module sqrt_bcd_display import sqrt_disp_pkg::*; #(
    parameter int WIDTH       = 12,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   a,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic               blank_lz,
    output logic               busy,
    output logic               valid,
    output logic [WIDTH/2-1:0] root,
    output logic [WIDTH/2:0]   rem,
    output logic [DIGITS-1:0]  an,
    output logic [6:0]         ca
);

    localparam int H  = WIDTH / 2;
    localparam int CW = cw(3 * WIDTH);
    localparam int RW = cw(REFRESH_DIV);
    localparam int IW = cw(DIGITS);
    localparam int BW = 4 * DIGITS;

    if (WIDTH % 2 != 0 || WIDTH < 4 || DIGITS < 1 || REFRESH_DIV < 2 ||
        (longint'(1) << WIDTH) - 1 >= pow10(DIGITS)) begin : g_bad_params
        $error("sqrt_bcd_display: illegal WIDTH/DIGITS/REFRESH_DIV combination");
    end

    state_t          state, nstate;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] x, a_cap, cbin;
    logic [H-1:0]    rt;
    logic [H:0]      rm, rm_n;
    logic [H+2:0]    rmt, trial;
    logic            ge, load, cbusy, cdone, show;
    logic [BW-1:0]   cbcd, s0, s1, s2, sel;
    logic [RW-1:0]   rc;
    logic [IW-1:0]   idx, nidx;
    logic [3:0]      d;
    logic [6:0]      ca_n;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_conv (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .bin   (cbin),
        .busy  (cbusy),
        .done  (cdone),
        .bcd   (cbcd)
    );

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nstate;
    end

    // sequencing, converter launch and operand pick (a, root, rem in turn)
    always_comb begin
        nstate = state == IDLE ? (start ? SQRT : IDLE)
               : state == SQRT ? (cnt == CW'(H - 1) ? CONV : SQRT)
               : state == CONV ? (cnt == CW'(3 * WIDTH - 1) ? DONE : CONV)
               : IDLE;
        load   = state == CONV && !cbusy;
        cbin   = cnt < CW'(WIDTH) ? a_cap : cnt < CW'(2 * WIDTH) ? WIDTH'(rt) : WIDTH'(rm);
    end

    // one restoring square-root step on the next operand bit pair
    always_comb begin
        rmt   = {rm, x[WIDTH-1 -: 2]};
        trial = (H + 3)'({rt, 2'b01});
        ge    = rmt >= trial;
        rm_n  = ge ? (H + 1)'(rmt - trial) : rmt[H:0];
    end

    // datapath; finished BCD values shift in so slots end as a, root, rem
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            x     <= '0;
            a_cap <= '0;
            rt    <= '0;
            rm    <= '0;
            root  <= '0;
            rem   <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
            s0    <= '0;
            s1    <= '0;
            s2    <= '0;
        end else begin
            cnt <= state != nstate ? '0 : cnt + 1'b1;
            if (state == IDLE && start) begin
                x     <= a;
                a_cap <= a;
                rt    <= '0;
                rm    <= '0;
                busy  <= 1'b1;
                valid <= 1'b0;
            end
            if (state == SQRT) begin
                x  <= x << 2;
                rt <= {rt[H-2:0], ge};
                rm <= rm_n;
            end
            if (cdone) {s2, s1, s0} <= {cbcd, s2, s1};
            if (state == DONE) begin
                root  <= rt;
                rem   <= rm;
                busy  <= 1'b0;
                valid <= 1'b1;
            end
        end
    end

    // pattern for the digit that will be lit after the next edge
    always_comb begin
        nidx = rc == RW'(REFRESH_DIV - 1) ? (idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1) : idx;
        sel  = mode == 2'b00 ? s0 : mode == 2'b10 ? s2 : s1;
        d    = 4'(sel >> {nidx, 2'b00});
        show = !blank_lz || nidx == '0 || (sel >> {nidx, 2'b00}) != '0;
        ca_n = busy ? SEG_DASH : !valid ? SEG_BLANK : show ? SEG_TAB[d] : SEG_BLANK;
    end

    // refresh timer and registered digit/segment drive
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rc  <= '0;
            idx <= '0;
            an  <= ~DIGITS'(1);
            ca  <= SEG_BLANK;
        end else begin
            rc  <= rc == RW'(REFRESH_DIV - 1) ? '0 : rc + 1'b1;
            idx <= nidx;
            an  <= ~(DIGITS'(1) << nidx);
            ca  <= ca_n;
        end
    end

endmodule

// File: tb/tb_sqrt_bcd_display.sv
// tb_sqrt_bcd_display: random and directed checks against a cycle-count reference model
module tb_sqrt_bcd_display;

    localparam int W   = 12;
    localparam int D   = 4;
    localparam int RD  = 4;
    localparam int LAT = 1 + W / 2 + 3 * W;

    logic           clk = 1'b0, reset = 1'b1, start = 1'b0, blank_lz = 1'b0;
    logic [W-1:0]   a = '0;
    logic [1:0]     mode = '0;
    logic           busy, valid;
    logic [W/2-1:0] root;
    logic [W/2:0]   rem;
    logic [D-1:0]   an;
    logic [6:0]     ca;

    int errors = 0, checks = 0, cyc = 0, rises = 0, acc = 0;
    logic pv = 1'b0;

    int m_left, m_a, m_root, m_rem, n, m_v, m_idx;
    logic m_busy, m_valid;
    logic [D-1:0] e_an;
    logic [6:0]   e_ca;

    logic [6:0] segs [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    sqrt_bcd_display #(.WIDTH(W), .DIGITS(D), .REFRESH_DIV(RD)) dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .start    (start),
        .mode     (mode),
        .blank_lz (blank_lz),
        .busy     (busy),
        .valid    (valid),
        .root     (root),
        .rem      (rem),
        .an       (an),
        .ca       (ca)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function automatic logic [6:0] dig(input int v, input int i, input logic blz);
        int p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        if (i != 0 && blz && v / p == 0) return 7'h7F;
        return segs[(v / p) % 10];
    endfunction

    // reference: operation is a fixed countdown, digit index follows the cycle count
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left = 0; m_a = 0; m_root = 0; m_rem = 0; n = 0;
            m_busy = 1'b0; m_valid = 1'b0;
            e_an = ~D'(1); e_ca = 7'h7F;
        end else begin
            n++;
            m_idx = (n / RD) % D;
            e_an  = ~(D'(1) << m_idx);
            m_v   = int'(mode) == 0 ? m_a : int'(mode) == 2 ? m_rem : m_root;
            e_ca  = m_busy ? 7'h3F : !m_valid ? 7'h7F : dig(m_v, m_idx, blank_lz);
            if (m_left == 0) begin
                if (start) begin
                    m_left = LAT; m_busy = 1'b1; m_valid = 1'b0; m_a = int'(a);
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0; m_valid = 1'b1;
                    m_root = isqrt(m_a);
                    m_rem  = m_a - m_root * m_root;
                end
            end
        end
    end

    // every-cycle comparison against the reference
    always @(negedge clk) begin
        chk("busy",  32'(busy),  32'(m_busy));
        chk("valid", 32'(valid), 32'(m_valid));
        chk("root",  32'(root),  32'(m_root));
        chk("rem",   32'(rem),   32'(m_rem));
        chk("an",    32'(an),    32'(e_an));
        chk("ca",    32'(ca),    32'(e_ca));
    end

    always @(negedge clk) begin
        if (valid === 1'b1 && pv !== 1'b1) rises++;
        pv = valid;
    end

    task automatic go(input logic [W-1:0] v);
        @(negedge clk);
        a = v; start = 1'b1;
        @(negedge clk);
        acc = cyc; start = 1'b0; a = W'($urandom);
    endtask

    task automatic pulse(input logic [W-1:0] v);
        @(negedge clk);
        a = v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        int t = 0;
        while (valid !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        lat = cyc - acc;
        if (valid !== 1'b1) chk("valid_timeout", 32'(valid), 32'd1);
    endtask

    task automatic show(input string nm, input logic [27:0] exp);
        logic [27:0] got = '1;
        repeat (D * RD) begin
            @(negedge clk);
            for (int i = 0; i < D; i++)
                if (an[i] == 1'b0) got[7*i +: 7] = ca;
        end
        chk(nm, 32'(got), 32'(exp));
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_busy"},  32'(busy),  32'd0);
        chk({nm, "_valid"}, 32'(valid), 32'd0);
        chk({nm, "_root"},  32'(root),  32'd0);
        chk({nm, "_rem"},   32'(rem),   32'd0);
        chk({nm, "_an"},    32'(an),    32'b1110);
        chk({nm, "_ca"},    32'(ca),    32'h7F);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, r0;
        logic [W-1:0] v;
        repeat (3) @(negedge clk);
        chk_reset("rst");
        reset = 1'b0;

        go(144);
        @(negedge clk);
        chk("busy_dash", 32'(ca), 32'h3F);
        wait_valid(lat);
        chk("lat_144", 32'(lat), 32'd43);
        chk("root_144", 32'(root), 32'd12);
        chk("rem_144", 32'(rem), 32'd0);
        mode = 2'b01; blank_lz = 1'b1;
        show("disp_144", {7'h7F, 7'h7F, 7'h79, 7'h24});

        go(4095);
        wait_valid(lat);
        chk("lat_4095", 32'(lat), 32'd43);
        chk("root_4095", 32'(root), 32'd63);
        chk("rem_4095", 32'(rem), 32'd126);
        mode = 2'b00; blank_lz = 1'b0;
        show("disp_4095", {7'h19, 7'h40, 7'h10, 7'h12});
        mode = 2'b10;
        show("disp_0126", {7'h40, 7'h79, 7'h24, 7'h02});

        go(0);
        wait_valid(lat);
        chk("root_0", 32'(root), 32'd0);
        chk("rem_0", 32'(rem), 32'd0);
        blank_lz = 1'b1;
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            show("disp_zero", {7'h7F, 7'h7F, 7'h7F, 7'h40});
        end

        r0 = rises;
        go(2);
        repeat (1) @(negedge clk);
        pulse(9);
        repeat (14) @(negedge clk);
        pulse(9);
        wait_valid(lat);
        chk("lat_ignored", 32'(lat), 32'd43);
        chk("root_2", 32'(root), 32'd1);
        chk("rem_2", 32'(rem), 32'd1);
        repeat (60) @(negedge clk);
        chk("valid_once", 32'(rises - r0), 32'd1);

        go(77);
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_reset("midrst");
        @(negedge clk);
        reset = 1'b0;
        go(100);
        wait_valid(lat);
        chk("lat_100", 32'(lat), 32'd43);
        chk("root_100", 32'(root), 32'd10);
        chk("rem_100", 32'(rem), 32'd0);

        repeat (20) begin
            v = W'($urandom_range(0, (1 << W) - 1));
            mode = 2'($urandom); blank_lz = 1'($urandom);
            go(v);
            repeat (38) begin
                @(negedge clk);
                mode = 2'($urandom); blank_lz = 1'($urandom);
                start = $urandom_range(0, 3) == 0;
                a = W'($urandom);
            end
            start = 1'b0;
            wait_valid(lat);
            chk("rnd_lat", 32'(lat), 32'd43);
            chk("rnd_root", 32'(root), 32'(isqrt(int'(v))));
            repeat (24) begin
                @(negedge clk);
                mode = 2'($urandom); blank_lz = 1'($urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
